sp_ram_arbiter: RTL and testbench

- Shares one single-port 32-bit SRAM/BRAM between two requester ports: port 0 (core data/instruction side) and port 1 (AXI/debug side).
- Sits in front of the SP RAM wrapper and drives its en/addr/wdata/we/be inputs. Read data from the RAM arrives one cycle after enable.
- Both ports use the core req/gnt/rvalid protocol: grant is given in the same cycle as the request, and the response (rvalid) follows one cycle later.
- Contention is resolved round-robin, and each response is routed back to the port that issued it.

---
 rtl/sp_ram_arbiter.sv | 102 ++++++++++
 tb/tb_sp_ram_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: round-robin arbiter sharing one single-port RAM between
// two requesters (port 0: core side, port 1: AXI/debug side).
//
// Handshake (both ports): a requester raises req_i with addr/we/be/wdata and
// holds them stable until gnt_o is seen high in the same cycle. gnt_o is
// combinational and only asserted while the matching req_i is high. Exactly
// one cycle after a grant, rvalid_o pulses for that port, for reads and
// writes alike. rvalid cannot be stalled; requesters must always accept it.
module sp_ram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  // port 0
  input  logic                    p0_req_i,
  output logic                    p0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,
  // port 1
  input  logic                    p1_req_i,
  output logic                    p1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,
  // memory side
  output logic                    mem_en_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  // Port preferred on the next contention, and the one-deep response pipe.
  logic prio_q, prio_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_port_q, rsp_port_d;

  logic both_req;
  logic sel_p1;

  // Grant decision: a lone requester always wins, contention goes to prio_q.
  always_comb begin
    both_req = p0_req_i & p1_req_i;
    p0_gnt_o = p0_req_i & (~p1_req_i | ~prio_q);
    p1_gnt_o = p1_req_i & (~p0_req_i | prio_q);
    sel_p1   = p1_gnt_o;
  end

  // Memory request mux; defaults to port 0 fields when nothing is granted.
  always_comb begin
    mem_en_o = p0_gnt_o | p1_gnt_o;
    if (sel_p1) begin
      mem_addr_o  = p1_addr_i;
      mem_we_o    = p1_we_i;
      mem_be_o    = p1_be_i;
      mem_wdata_o = p1_wdata_i;
    end else begin
      mem_addr_o  = p0_addr_i;
      mem_we_o    = p0_we_i;
      mem_be_o    = p0_be_i;
      mem_wdata_o = p0_wdata_i;
    end
  end

  // Next-state: flip priority away from the winner only on contention.
  always_comb begin
    prio_d      = both_req ? ~sel_p1 : prio_q;
    rsp_valid_d = mem_en_o;
    rsp_port_d  = sel_p1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      prio_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_port_q  <= rsp_port_d;
    end
  end

  // Response routing: read data is shared, rvalid steers it to the issuer.
  always_comb begin
    p0_rvalid_o = rsp_valid_q & ~rsp_port_q;
    p1_rvalid_o = rsp_valid_q & rsp_port_q;
    p0_rdata_o  = mem_rdata_i;
    p1_rdata_o  = mem_rdata_i;
  end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb_sp_ram_arbiter: directed and random traffic against sp_ram_arbiter with
// a behavioural single-port RAM and a response scoreboard.
module tb_sp_ram_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int W  = 2 + DW;   // {port, is_read, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn_i;
  always #5 clk = ~clk;

  logic          p0_req_i, p0_gnt_o, p0_we_i, p0_rvalid_o;
  logic [AW-1:0] p0_addr_i;
  logic [BW-1:0] p0_be_i;
  logic [DW-1:0] p0_wdata_i, p0_rdata_o;
  logic          p1_req_i, p1_gnt_o, p1_we_i, p1_rvalid_o;
  logic [AW-1:0] p1_addr_i;
  logic [BW-1:0] p1_be_i;
  logic [DW-1:0] p1_wdata_i, p1_rdata_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [BW-1:0] mem_be_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn_i(rstn_i),
    .p0_req_i(p0_req_i), .p0_gnt_o(p0_gnt_o), .p0_addr_i(p0_addr_i),
    .p0_we_i(p0_we_i), .p0_be_i(p0_be_i), .p0_wdata_i(p0_wdata_i),
    .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_gnt_o(p1_gnt_o), .p1_addr_i(p1_addr_i),
    .p1_we_i(p1_we_i), .p1_be_i(p1_be_i), .p1_wdata_i(p1_wdata_i),
    .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // ---------------- RAM environment model ----------------
  logic [DW-1:0] ram    [0:8191];
  logic [DW-1:0] sh_mem [0:8191];   // bench-side expected contents

  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < BW; b++)
          if (mem_be_o[b]) ram[mem_addr_o[AW-1:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
      mem_rdata_i <= ram[mem_addr_o[AW-1:2]];
    end
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic          m_prio;
  logic          last_g0, last_g1;
  logic [DW-1:0] last_rdata_p0, last_rdata_p1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_p0(input logic req, input logic we, input logic [AW-1:0] addr,
                        input logic [BW-1:0] be, input logic [DW-1:0] wd);
    p0_req_i = req; p0_we_i = we; p0_addr_i = addr; p0_be_i = be; p0_wdata_i = wd;
  endtask

  task automatic set_p1(input logic req, input logic we, input logic [AW-1:0] addr,
                        input logic [BW-1:0] be, input logic [DW-1:0] wd);
    p1_req_i = req; p1_we_i = we; p1_addr_i = addr; p1_be_i = be; p1_wdata_i = wd;
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] d);
    ram[addr[AW-1:2]]    = d;
    sh_mem[addr[AW-1:2]] = d;
  endtask

  // One clock cycle: inputs are already applied; checks run on the falling edge.
  task automatic cycle();
    logic [W-1:0]  e;
    logic          eg0, eg1, both;
    logic [AW-1:0] ea;
    logic          ewe;
    logic [BW-1:0] ebe;
    logic [DW-1:0] ewd;
    @(negedge clk);
    // responses for the previous cycle's grant
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("p0_rvalid", {63'd0, p0_rvalid_o}, {63'd0, ~e[W-1]});
      check("p1_rvalid", {63'd0, p1_rvalid_o}, {63'd0, e[W-1]});
      if (e[W-2]) check(e[W-1] ? "p1_rdata" : "p0_rdata",
                        {32'd0, (e[W-1] ? p1_rdata_o : p0_rdata_o)}, {32'd0, e[DW-1:0]});
    end else begin
      check("p0_rvalid_idle", {63'd0, p0_rvalid_o}, 64'd0);
      check("p1_rvalid_idle", {63'd0, p1_rvalid_o}, 64'd0);
    end
    if (p0_rvalid_o) last_rdata_p0 = p0_rdata_o;
    if (p1_rvalid_o) last_rdata_p1 = p1_rdata_o;
    // grant decision from the reference priority
    both = p0_req_i & p1_req_i;
    eg0  = p0_req_i & (~p1_req_i | ~m_prio);
    eg1  = p1_req_i & (~p0_req_i | m_prio);
    check("p0_gnt", {63'd0, p0_gnt_o}, {63'd0, eg0});
    check("p1_gnt", {63'd0, p1_gnt_o}, {63'd0, eg1});
    check("mem_en", {63'd0, mem_en_o}, {63'd0, eg0 | eg1});
    ea  = eg1 ? p1_addr_i  : p0_addr_i;
    ewe = eg1 ? p1_we_i    : p0_we_i;
    ebe = eg1 ? p1_be_i    : p0_be_i;
    ewd = eg1 ? p1_wdata_i : p0_wdata_i;
    check("mem_addr", {49'd0, mem_addr_o}, {49'd0, ea});
    if (eg0 | eg1) begin
      check("mem_we",    {63'd0, mem_we_o},    {63'd0, ewe});
      check("mem_be",    {60'd0, mem_be_o},    {60'd0, ebe});
      check("mem_wdata", {32'd0, mem_wdata_o}, {32'd0, ewd});
    end
    last_g0 = p0_gnt_o;
    last_g1 = p1_gnt_o;
    if (!rstn_i) begin
      m_prio = 1'b0;            // reset edge discards this cycle's response
    end else begin
      if (eg0 | eg1) begin
        exp_q.push_back({eg1, ~ewe, sh_mem[ea[AW-1:2]]});
        if (ewe)
          for (int b = 0; b < BW; b++)
            if (ebe[b]) sh_mem[ea[AW-1:2]][8*b +: 8] = ewd[8*b +: 8];
      end
      if (both) m_prio = ~m_prio;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic p0_busy, p1_busy;

  initial begin
    m_prio = 1'b0;
    last_rdata_p0 = '0;
    last_rdata_p1 = '0;
    for (int i = 0; i < 8192; i++) begin ram[i] = '0; sh_mem[i] = '0; end
    mem_rdata_i = '0;
    rstn_i = 1'b0;
    preload(15'h0000, 32'h11111111);
    preload(15'h0004, 32'h22222222);

    // Reset with both ports requesting reads.
    set_p0(1, 0, 15'h0000, 4'hF, '0);
    set_p1(1, 0, 15'h0004, 4'hF, '0);
    @(posedge clk); #1;
    cycle();
    check("reset_gnt0", {63'd0, last_g0}, 64'd1);
    cycle();
    rstn_i = 1'b1;
    cycle();
    check("first_contend_p0", {63'd0, last_g0}, 64'd1);
    cycle();
    check("second_contend_p1", {63'd0, last_g1}, 64'd1);
    set_p0(0, 0, '0, '0, '0);
    set_p1(0, 0, '0, '0, '0);
    cycle();

    // Single-port write then read.
    set_p0(1, 1, 15'h0010, 4'hF, 32'hDEADBEEF);
    cycle();
    set_p0(1, 0, 15'h0010, 4'hF, '0);
    cycle();
    set_p0(0, 0, '0, '0, '0);
    cycle();
    check("p0_readback", {32'd0, last_rdata_p0}, {32'd0, 32'hDEADBEEF});

    // Four cycles of contention: 0,1,0,1.
    set_p0(1, 0, 15'h0000, 4'hF, '0);
    set_p1(1, 0, 15'h0004, 4'hF, '0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("contend_gnt1", {63'd0, last_g1}, {63'd0, (i % 2 == 1)});
    end
    set_p0(0, 0, '0, '0, '0);
    set_p1(0, 0, '0, '0, '0);
    cycle();
    check("contend_rdata_p0", {32'd0, last_rdata_p0}, {32'd0, 32'h11111111});
    check("contend_rdata_p1", {32'd0, last_rdata_p1}, {32'd0, 32'h22222222});

    // Byte-lane write on port 1.
    preload(15'h0020, 32'h00000000);
    set_p1(1, 1, 15'h0020, 4'b0101, 32'hAABBCCDD);
    cycle();
    set_p1(1, 0, 15'h0020, 4'hF, '0);
    cycle();
    set_p1(0, 0, '0, '0, '0);
    cycle();
    check("byte_merge", {32'd0, last_rdata_p1}, {32'd0, 32'h00BB00DD});

    // Uncontended port-1 stream must not move the priority.
    set_p1(1, 0, 15'h0004, 4'hF, '0);
    for (int i = 0; i < 3; i++) cycle();
    set_p0(1, 0, 15'h0000, 4'hF, '0);
    cycle();
    check("after_stream_p0_wins", {63'd0, last_g0}, 64'd1);
    cycle();
    check("next_contend_p1", {63'd0, last_g1}, 64'd1);
    set_p0(0, 0, '0, '0, '0);
    set_p1(0, 0, '0, '0, '0);
    cycle();

    // Reset in the cycle after a p0 read grant.
    set_p0(1, 0, 15'h0010, 4'hF, '0);
    cycle();
    set_p0(0, 0, '0, '0, '0);
    rstn_i = 1'b0;
    cycle();
    rstn_i = 1'b1;
    cycle();
    check("post_reset_rvalid0", {63'd0, p0_rvalid_o}, 64'd0);
    // Grant coinciding with reset: its response must be dropped.
    set_p0(1, 0, 15'h0010, 4'hF, '0);
    rstn_i = 1'b0;
    cycle();
    set_p0(0, 0, '0, '0, '0);
    rstn_i = 1'b1;
    cycle();
    cycle();

    // Random traffic; an ungranted requester holds its request.
    p0_busy = 1'b0;
    p1_busy = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!p0_busy)
        set_p0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 7) * 4), BW'($urandom_range(0, 15)), DW'($urandom));
      if (!p1_busy)
        set_p1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 7) * 4), BW'($urandom_range(0, 15)), DW'($urandom));
      cycle();
      p0_busy = p0_req_i & ~last_g0;
      p1_busy = p1_req_i & ~last_g1;
    end
    set_p0(0, 0, '0, '0, '0);
    set_p1(0, 0, '0, '0, '0);
    cycle();
    cycle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
